seg7_scan_n: RTL and testbench
==============================

Name: seg7_scan_n

Overview:
- Parametrised successor to the fixed 8-digit seven-segment scanner.
- Time-multiplexes DIGITS common-anode digits from a shadow-buffered data word.
- Adds tear-free frame-synchronous update, per-digit decimal points, leading-zero blanking, PWM brightness and selectable output polarity.
- Sits between the display-source mux of the top-level computer and the board pins.

Parameters:
- DIGITS, 8: number of digits, 1..8.
- SCAN_DIV, 15: each digit is lit for 2^SCAN_DIV clk cycles. Must be greater than PWM_BITS.
- PWM_BITS, 4: brightness resolution in bits.
- ACTIVE_LOW, 1: 1 = o_seg/o_sel asserted low (board default); 0 = both outputs inverted.

Ports:
- clk  in  1  system clock (100 MHz on board).
- rstn  in  1  asynchronous active-low reset.
- i_data  in  8*DIGITS  display data. Hex mode uses bits [4*DIGITS-1:0], nibble k goes to digit k. Graph mode uses byte k as raw segments for digit k.
- i_dp  in  DIGITS  decimal-point enables, hex mode only.
- disp_mode  in  1  0 = hex, 1 = graph (raw).
- i_blank_lz  in  1  leading-zero blanking enable, hex mode only.
- i_load  in  1  one-cycle strobe; captures i_data/i_dp/disp_mode/i_blank_lz.
- i_bright  in  PWM_BITS  brightness level, live (not captured).
- o_seg  out  8  segments {dp,g,f,e,d,c,b,a}, registered.
- o_sel  out  DIGITS  digit anodes, one-hot active, registered.
- o_frame  out  1  one-cycle pulse at each frame start.

Behaviour:
- Reset values: all internal state returns to reset values immediately, asynchronously, including mid-frame.
  - scan counter = 0, digit index = 0.
  - display buffer and pending buffer = 0, pending-valid = 0.
  - o_seg = all segments off (8'hFF when ACTIVE_LOW=1).
  - o_sel = all digits off.
  - o_frame = 0.
- Scan counter:
  - SCAN_DIV bits wide, free-running.
  - When it wraps (all ones to 0), the digit index advances; digit index wraps from DIGITS-1 to 0. DIGITS need not be a power of 2.
  - Frame period = DIGITS*2^SCAN_DIV cycles.
- Frame boundary: the edge where the digit index goes DIGITS-1 -> 0.
  - o_frame is high for exactly the cycle after that edge.
  - If pending-valid is set, display buffer <= pending buffer and pending-valid clears.
- Loading:
  - i_load in any other cycle: pending buffer <= inputs and pending-valid sets. A later load before the boundary overwrites the pending buffer; last load wins.
  - i_load coincident with the boundary edge: the inputs go directly into the display buffer, and pending-valid clears.
  - The display never shows a mix of two loads.
- PWM:
  - pwm = scan counter[SCAN_DIV-1 -: PWM_BITS].
  - The anode is enabled while pwm <= i_bright. Duty = (i_bright+1)/2^PWM_BITS; all ones = always on.
  - Segments stay driven while the anode is disabled.
- Hex decode:
  - Codes as used by the existing display: 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8 8:80 9:90 A:88 B:83 C:C6 D:A1 E:86 F:8E.
  - Bit7 (dp) = ~i_dp[k].
- Leading-zero blanking (hex mode, blank flag set):
  - Digit k > 0 is blanked (segments a..g off) if nibbles k..DIGITS-1 are all zero.
  - Digit 0 is never blanked.
  - The dp of a blanked digit still follows i_dp[k].
- Graph mode: o_seg = byte k verbatim (ACTIVE_LOW=1 view); i_dp and blanking are ignored.
- Polarity: for ACTIVE_LOW=0, o_seg and o_sel are the bitwise inverse of the ACTIVE_LOW=1 values, including reset values.
- Latency: o_seg/o_sel reflect the counter state with exactly 1 clk of latency. There is no glitch on the boundary cycle.

Test Plan:
Benches use DIGITS=4, SCAN_DIV=4, PWM_BITS=2, ACTIVE_LOW=1 unless stated.
1. Reset: assert rstn=0 mid-frame -> o_seg=FF, o_sel=1111, o_frame=0 immediately. After release, the first o_frame pulse occurs at cycle 64 (+1 latency).
2. Load 0x1234, hex, i_bright=3, issued mid-frame -> old data is held until o_frame. The next frame shows sel 1110/seg 99, 1101/B0, 1011/A4, 0111/F9, 16 cycles each.
3. Two loads (0x1111, then 0x2222) within one frame -> the next frame shows only 2222 (A4 on every digit). A load on the boundary edge is displayed in that same frame.
4. Blanking on: data 0x0050 -> digits 3,2 FF, digit1 92, digit0 C0. Data 0x0000 -> digit0 C0 only. i_dp=1000 with 0x0000 -> digit3 seg 7F.
5. i_bright=1 -> each anode is low for 8 of its 16 cycles (pwm 0,1). i_bright=0 -> 4 of 16.
6. Graph mode, bytes {01,80,FF,00} -> o_seg equals each byte verbatim. ACTIVE_LOW=0 build -> o_seg/o_sel are the exact inverses, and reset o_seg=00.

Source files
------------

// File: rtl/seg7_scan_n_if.sv
// Display-data and pin bundle for seg7_scan_n: the display-source side drives data and strobes,
// the scanner drives the segment, anode and frame-pulse pins.
interface seg7_scan_n_if #(
    parameter int DIGITS   = 8,
    parameter int PWM_BITS = 4
);
    logic [8*DIGITS-1:0] i_data;
    logic [DIGITS-1:0]   i_dp;
    logic                disp_mode;
    logic                i_blank_lz;
    logic                i_load;
    logic [PWM_BITS-1:0] i_bright;
    logic [7:0]          o_seg;
    logic [DIGITS-1:0]   o_sel;
    logic                o_frame;

    modport master (
        output i_data, i_dp, disp_mode, i_blank_lz, i_load, i_bright,
        input  o_seg, o_sel, o_frame
    );

    modport slave (
        input  i_data, i_dp, disp_mode, i_blank_lz, i_load, i_bright,
        output o_seg, o_sel, o_frame
    );
endinterface

// File: rtl/seg7_scan_n.sv
// Time-multiplexed common-anode seven-segment scanner with frame-synchronous shadow buffering,
// leading-zero blanking, per-digit decimal points, PWM brightness and selectable pin polarity.
module seg7_scan_n #(
    parameter int DIGITS     = 8,
    parameter int SCAN_DIV   = 15,
    parameter int PWM_BITS   = 4,
    parameter int ACTIVE_LOW = 1
) (
    input  logic          clk,
    input  logic          rstn,
    seg7_scan_n_if.slave  bus
);
    localparam int                DIG_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [DIG_W-1:0]  LAST_DIG = DIG_W'(DIGITS - 1);
    localparam logic [7:0]        SEG_OFF  = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [DIGITS-1:0] SEL_OFF  = (ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    typedef struct packed {
        logic [8*DIGITS-1:0] data;
        logic [DIGITS-1:0]   dp;
        logic                mode;
        logic                blz;
    } buf_t;

    logic [SCAN_DIV-1:0] cnt_q, cnt_d;
    logic [DIG_W-1:0]    dig_q, dig_d;
    buf_t                disp_q, disp_d, pend_q, pend_d, load_buf;
    logic                pvld_q, pvld_d;
    logic [7:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   sel_q, sel_d;
    logic                frame_q, frame_d;
    logic                wrap, boundary;

    function automatic logic [7:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 8'hC0;  4'h1: hex7 = 8'hF9;  4'h2: hex7 = 8'hA4;  4'h3: hex7 = 8'hB0;
            4'h4: hex7 = 8'h99;  4'h5: hex7 = 8'h92;  4'h6: hex7 = 8'h82;  4'h7: hex7 = 8'hF8;
            4'h8: hex7 = 8'h80;  4'h9: hex7 = 8'h90;  4'hA: hex7 = 8'h88;  4'hB: hex7 = 8'h83;
            4'hC: hex7 = 8'hC6;  4'hD: hex7 = 8'hA1;  4'hE: hex7 = 8'h86;  default: hex7 = 8'h8E;
        endcase
    endfunction

    // Scan position and shadow-buffer control
    always_comb begin
        wrap     = &cnt_q;
        boundary = wrap && (dig_q == LAST_DIG);
        cnt_d    = cnt_q + 1'b1;
        dig_d    = dig_q;
        if (wrap) begin
            dig_d = (dig_q == LAST_DIG) ? '0 : dig_q + 1'b1;
        end

        load_buf.data = bus.i_data;
        load_buf.dp   = bus.i_dp;
        load_buf.mode = bus.disp_mode;
        load_buf.blz  = bus.i_blank_lz;

        disp_d = disp_q;
        pend_d = pend_q;
        pvld_d = pvld_q;
        if (boundary) begin
            // A load landing on the frame edge bypasses the pending stage entirely.
            if (bus.i_load) begin
                disp_d = load_buf;
            end else if (pvld_q) begin
                disp_d = pend_q;
            end
            pvld_d = 1'b0;
        end else if (bus.i_load) begin
            pend_d = load_buf;
            pvld_d = 1'b1;
        end
        frame_d = boundary;
    end

    logic [DIGITS-1:0]   blank;
    logic                allz;
    logic [3:0]          nib;
    logic [7:0]          byt, hexv, seg_al;
    logic                dpk, blk, lit;
    logic [PWM_BITS-1:0] pwm;
    logic [DIGITS-1:0]   sel_al;

    // Digit decode from the display buffer; everything here is computed in the active-low view
    always_comb begin
        allz  = 1'b1;
        blank = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            allz = allz & (disp_q.data[4*k +: 4] == 4'h0);
            if (k > 0) begin
                blank[k] = allz;
            end
        end

        nib = '0;
        byt = '0;
        dpk = 1'b0;
        blk = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (dig_q == DIG_W'(k)) begin
                nib = disp_q.data[4*k +: 4];
                byt = disp_q.data[8*k +: 8];
                dpk = disp_q.dp[k];
                blk = blank[k];
            end
        end

        hexv = hex7(nib);
        if (disp_q.mode) begin
            seg_al = byt;
        end else begin
            seg_al = {~dpk, (disp_q.blz && blk) ? 7'h7F : hexv[6:0]};
        end

        pwm    = cnt_q[SCAN_DIV-1 -: PWM_BITS];
        lit    = (pwm <= bus.i_bright);
        sel_al = {DIGITS{1'b1}};
        if (lit) begin
            sel_al = ~(DIGITS'(1) << dig_q);
        end

        seg_d = (ACTIVE_LOW != 0) ? seg_al : ~seg_al;
        sel_d = (ACTIVE_LOW != 0) ? sel_al : ~sel_al;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q   <= '0;
            dig_q   <= '0;
            disp_q  <= '0;
            pend_q  <= '0;
            pvld_q  <= 1'b0;
            seg_q   <= SEG_OFF;
            sel_q   <= SEL_OFF;
            frame_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            dig_q   <= dig_d;
            disp_q  <= disp_d;
            pend_q  <= pend_d;
            pvld_q  <= pvld_d;
            seg_q   <= seg_d;
            sel_q   <= sel_d;
            frame_q <= frame_d;
        end
    end

    assign bus.o_seg   = seg_q;
    assign bus.o_sel   = sel_q;
    assign bus.o_frame = frame_q;
endmodule

// File: tb/tb_seg7_scan_n.sv
// Directed bench for seg7_scan_n (4 digits, 16-cycle digit slot, 2-bit PWM) with an
// inverted-polarity twin sharing the same inputs.
module tb_seg7_scan_n;
    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 4;
    localparam int PWM_BITS = 2;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    seg7_scan_n_if #(.DIGITS(DIGITS), .PWM_BITS(PWM_BITS)) ifc ();
    seg7_scan_n_if #(.DIGITS(DIGITS), .PWM_BITS(PWM_BITS)) ifc_n ();

    assign ifc_n.i_data     = ifc.i_data;
    assign ifc_n.i_dp       = ifc.i_dp;
    assign ifc_n.disp_mode  = ifc.disp_mode;
    assign ifc_n.i_blank_lz = ifc.i_blank_lz;
    assign ifc_n.i_load     = ifc.i_load;
    assign ifc_n.i_bright   = ifc.i_bright;

    seg7_scan_n #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .PWM_BITS(PWM_BITS), .ACTIVE_LOW(1))
        dut (.clk(clk), .rstn(rstn), .bus(ifc.slave));
    seg7_scan_n #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .PWM_BITS(PWM_BITS), .ACTIVE_LOW(0))
        dut_n (.clk(clk), .rstn(rstn), .bus(ifc_n.slave));

    typedef struct {
        logic [31:0] data;
        logic [3:0]  dp;
        logic        mode;
        logic        blz;
        logic [31:0] exp;   // {d3,d2,d1,d0} active-low segment bytes
    } vec_t;

    int errors = 0;
    int checks = 0;
    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_frame();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ifc.o_frame && n < 200);
        if (!ifc.o_frame) begin
            checks++;
            errors++;
            $display("FAIL frame_wait: no o_frame within %0d cycles, expected a pulse", n);
        end
    endtask

    task automatic load(input logic [31:0] data, input logic [3:0] dp, input logic mode,
                        input logic blz);
        ifc.i_data     = data;
        ifc.i_dp       = dp;
        ifc.disp_mode  = mode;
        ifc.i_blank_lz = blz;
        ifc.i_load     = 1'b1;
        @(negedge clk);
        ifc.i_load     = 1'b0;
    endtask

    // Starts on the o_frame cycle; samples each digit at its first (always lit) scan cycle.
    task automatic check_frame(input string name, input logic [31:0] exp);
        logic [7:0] e, ne;
        logic [3:0] s, ns;
        for (int d = 0; d < DIGITS; d++) begin
            step((d == 0) ? 1 : 16);
            e  = exp[8*d +: 8];
            ne = ~e;
            s  = ~(4'b0001 << d);
            ns = ~s;
            chk($sformatf("%s_d%0d_seg", name, d), {24'h0, ifc.o_seg}, {24'h0, e});
            chk($sformatf("%s_d%0d_sel", name, d), {28'h0, ifc.o_sel}, {28'h0, s});
            chk($sformatf("%s_d%0d_inv_seg", name, d), {24'h0, ifc_n.o_seg}, {24'h0, ne});
            chk($sformatf("%s_d%0d_inv_sel", name, d), {28'h0, ifc_n.o_sel}, {28'h0, ns});
        end
    endtask

    task automatic count_to_frame(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ifc.o_frame && n < 200);
        chk(name, n, 64);
    endtask

    task automatic pwm_window(input logic [1:0] br, input int exp_lit);
        int lit, segok;
        ifc.i_bright = br;
        wait_frame();
        lit   = 0;
        segok = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (ifc.o_sel == 4'b1110) lit++;
            if (ifc.o_sel == 4'b1111 || ifc.o_sel == 4'b1110) segok += (ifc.o_seg == 8'h99) ? 1 : 0;
        end
        chk($sformatf("pwm_lit_b%0d", br), lit, exp_lit);
        chk($sformatf("pwm_seg_held_b%0d", br), segok, 16);
    endtask

    initial begin
        tbl[0] = '{32'h0000_1234, 4'b0000, 1'b0, 1'b0, 32'hF9A4B099};
        tbl[1] = '{32'h0000_0050, 4'b0000, 1'b0, 1'b1, 32'hFFFF92C0};
        tbl[2] = '{32'h0000_0000, 4'b0000, 1'b0, 1'b1, 32'hFFFFFFC0};
        tbl[3] = '{32'h0000_0000, 4'b1000, 1'b0, 1'b1, 32'h7FFFFFC0};
        tbl[4] = '{32'h0180_FF00, 4'b1111, 1'b1, 1'b1, 32'h0180FF00};
        tbl[5] = '{32'h0000_ABCD, 4'b0101, 1'b0, 1'b0, 32'h8803C621};
        tbl[6] = '{32'h0000_9E07, 4'b0000, 1'b0, 1'b1, 32'h9086C0F8};
        tbl[7] = '{32'h0000_00F0, 4'b0010, 1'b0, 1'b0, 32'hC0C00EC0};

        ifc.i_data     = '0;
        ifc.i_dp       = '0;
        ifc.disp_mode  = 1'b0;
        ifc.i_blank_lz = 1'b0;
        ifc.i_load     = 1'b0;
        ifc.i_bright   = 2'd3;

        // Reset state and first frame timing
        #12;
        chk("rst_seg", {24'h0, ifc.o_seg}, 32'hFF);
        chk("rst_sel", {28'h0, ifc.o_sel}, 32'hF);
        chk("rst_frame", {31'h0, ifc.o_frame}, 32'h0);
        chk("rst_inv_seg", {24'h0, ifc_n.o_seg}, 32'h00);
        chk("rst_inv_sel", {28'h0, ifc_n.o_sel}, 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        count_to_frame("first_frame_cycle");
        check_frame("rst_buf", 32'hC0C0C0C0);

        for (int v = 0; v < 8; v++) begin
            wait_frame();
            load(tbl[v].data, tbl[v].dp, tbl[v].mode, tbl[v].blz);
            wait_frame();
            check_frame($sformatf("vec%0d", v), tbl[v].exp);
        end

        // Mid-frame load must not disturb the current frame
        wait_frame();
        load(32'h5678, 4'b0000, 1'b0, 1'b0);
        wait_frame();
        check_frame("v5678", 32'h92_82_F8_80);
        wait_frame();
        load(32'h1234, 4'b0000, 1'b0, 1'b0);
        step(14);
        chk("hold_old_seg", {24'h0, ifc.o_seg}, 32'h80);
        wait_frame();
        check_frame("v1234", 32'hF9A4B099);

        // Last of two loads in one frame wins
        wait_frame();
        load(32'h1111, 4'b0000, 1'b0, 1'b0);
        step(5);
        load(32'h2222, 4'b0000, 1'b0, 1'b0);
        wait_frame();
        check_frame("last_wins", 32'hA4A4A4A4);

        // Load on the boundary edge shows at once and discards the earlier pending load
        load(32'h3333, 4'b0000, 1'b0, 1'b0);
        step(13);
        ifc.i_data = 32'h4444;
        ifc.i_load = 1'b1;
        @(negedge clk);
        ifc.i_load = 1'b0;
        chk("bnd_frame", {31'h0, ifc.o_frame}, 32'h1);
        check_frame("bnd_load", 32'h99999999);
        wait_frame();
        check_frame("bnd_no_stale", 32'h99999999);

        // PWM duty on digit 0
        pwm_window(2'd1, 8);
        pwm_window(2'd0, 4);
        pwm_window(2'd2, 12);
        pwm_window(2'd3, 16);

        // Asynchronous reset in the middle of a frame
        wait_frame();
        step(20);
        #2;
        rstn = 1'b0;
        #1;
        chk("mid_rst_seg", {24'h0, ifc.o_seg}, 32'hFF);
        chk("mid_rst_sel", {28'h0, ifc.o_sel}, 32'hF);
        chk("mid_rst_frame", {31'h0, ifc.o_frame}, 32'h0);
        chk("mid_rst_inv_seg", {24'h0, ifc_n.o_seg}, 32'h00);
        chk("mid_rst_inv_sel", {28'h0, ifc_n.o_sel}, 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        count_to_frame("mid_rst_first_frame");
        check_frame("mid_rst_buf", 32'hC0C0C0C0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
